// File: rtl/lsu_arbiter.sv
// Two-requester front end for the single LSU port: round-robin arbitration with a
// bounded lock, one registered access cycle per command and a registered response.
`timescale 1ns/1ps
module lsu_arbiter #(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_req,
  input  logic        i_m1_req,
  input  logic        i_m0_wren,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [31:0] i_m1_wdata,
  input  logic [2:0]  i_m0_size,
  input  logic [2:0]  i_m1_size,
  input  logic        i_m0_lock,
  input  logic        i_m1_lock,
  output logic        o_m0_gnt,
  output logic        o_m1_gnt,
  output logic        o_m0_rvalid,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m0_rdata,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_num_byte,
  input  logic [31:0] i_ld_data,
  output logic        o_busy,
  output logic        o_owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);
  localparam logic [3:0] CNT_SAT    = 4'hF;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic        cmd_wren_q, cmd_wren_d;
  logic        cmd_lock_q, cmd_lock_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic [2:0]  cmd_size_q, cmd_size_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic [1:0]  req;
  logic        arb_en;
  logic        lock_hold;
  logic        winner;
  logic        grant;
  logic        sel_wren;
  logic        sel_lock;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_size;

  assign req = {i_m1_req, i_m0_req};

  // A locked owner keeps the port until its run hits LOCK_MAX while the other side waits.
  always_comb begin : arbitrate
    arb_en    = (state_q != S_ACCESS) && i_reset;
    lock_hold = (state_q == S_RESP) && cmd_lock_q && req[owner_q] &&
                !((lock_cnt_q >= LOCK_MAX_C) && req[~owner_q]);
    if (lock_hold) begin
      winner = owner_q;
    end else if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b01) begin
      winner = 1'b0;
    end else begin
      winner = ~last_q;
    end
    grant = arb_en && (req != 2'b00);
  end

  always_comb begin : select_fields
    if (winner) begin
      sel_wren  = i_m1_wren;
      sel_lock  = i_m1_lock;
      sel_addr  = i_m1_addr;
      sel_wdata = i_m1_wdata;
      sel_size  = i_m1_size;
    end else begin
      sel_wren  = i_m0_wren;
      sel_lock  = i_m0_lock;
      sel_addr  = i_m0_addr;
      sel_wdata = i_m0_wdata;
      sel_size  = i_m0_size;
    end
  end

  always_comb begin : next_state
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    cmd_wren_d  = cmd_wren_q;
    cmd_lock_d  = cmd_lock_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_size_d  = cmd_size_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (grant) begin
          if (!sel_lock) begin
            lock_cnt_d = '0;
          end else if (winner != owner_q) begin
            lock_cnt_d = 4'd1;
          end else if (lock_cnt_q != CNT_SAT) begin
            lock_cnt_d = lock_cnt_q + 4'd1;
          end
          last_d      = winner;
          owner_d     = winner;
          cmd_wren_d  = sel_wren;
          cmd_lock_d  = sel_lock;
          cmd_addr_d  = sel_addr;
          cmd_wdata_d = sel_wdata;
          cmd_size_d  = sel_size;
          state_d     = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (owner_q) begin
          rdata1_d = cmd_wren_q ? '0 : i_ld_data;
        end else begin
          rdata0_d = cmd_wren_q ? '0 : i_ld_data;
        end
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      lock_cnt_q  <= '0;
      cmd_wren_q  <= 1'b0;
      cmd_lock_q  <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_size_q  <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      cmd_wren_q  <= cmd_wren_d;
      cmd_lock_q  <= cmd_lock_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_size_q  <= cmd_size_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Command registers only change on a grant, so the LSU bus holds its last value outside ACCESS.
  assign o_lsu_addr  = cmd_addr_q;
  assign o_st_data   = cmd_wdata_q;
  assign o_num_byte  = cmd_size_q;
  assign o_lsu_wren  = (state_q == S_ACCESS) && cmd_wren_q;
  assign o_busy      = (state_q == S_ACCESS);
  assign o_owner     = owner_q;
  assign o_m0_gnt    = grant && !winner;
  assign o_m1_gnt    = grant && winner;
  assign o_m0_rvalid = (state_q == S_RESP) && !owner_q;
  assign o_m1_rvalid = (state_q == S_RESP) && owner_q;
  assign o_m0_rdata  = rdata0_q;
  assign o_m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed and randomized bench for lsu_arbiter with a behavioural LSU memory and a
// transaction-level arbitration/response reference model.
`timescale 1ns/1ps
module tb_lsu_arbiter;

  localparam int LOCK_MAX  = 4;
  localparam int PH_IDLE   = 0;
  localparam int PH_ACCESS = 1;
  localparam int PH_RESP   = 2;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        req  [2];
  logic        wren [2];
  logic        lck  [2];
  logic [31:0] addr [2];
  logic [31:0] wdata[2];
  logic [2:0]  size [2];

  logic        o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid;
  logic [31:0] o_m0_rdata, o_m1_rdata, o_lsu_addr, o_st_data;
  logic        o_lsu_wren, o_busy, o_owner;
  logic [2:0]  o_num_byte;
  logic [31:0] ld_data;

  bit   [8:0]  lsu_mem [4096];
  logic [7:0]  ref_mem [4096];
  logic [8:0]  ld_ent  [4];
  logic [7:0]  ld_byte [4];

  int          n_checks = 0;
  int          n_fail   = 0;

  int          ph, m_last, m_owner, m_cnt;
  bit          m_lock, c_wren;
  logic [31:0] c_addr, c_wdata;
  logic [2:0]  c_size;
  logic [31:0] exp_rdata[2];
  bit          seen_gnt[2];

  always #5 i_clk = ~i_clk;

  lsu_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_m0_req    (req[0]),
    .i_m1_req    (req[1]),
    .i_m0_wren   (wren[0]),
    .i_m1_wren   (wren[1]),
    .i_m0_addr   (addr[0]),
    .i_m1_addr   (addr[1]),
    .i_m0_wdata  (wdata[0]),
    .i_m1_wdata  (wdata[1]),
    .i_m0_size   (size[0]),
    .i_m1_size   (size[1]),
    .i_m0_lock   (lck[0]),
    .i_m1_lock   (lck[1]),
    .o_m0_gnt    (o_m0_gnt),
    .o_m1_gnt    (o_m1_gnt),
    .o_m0_rvalid (o_m0_rvalid),
    .o_m1_rvalid (o_m1_rvalid),
    .o_m0_rdata  (o_m0_rdata),
    .o_m1_rdata  (o_m1_rdata),
    .o_lsu_addr  (o_lsu_addr),
    .o_st_data   (o_st_data),
    .o_lsu_wren  (o_lsu_wren),
    .o_num_byte  (o_num_byte),
    .i_ld_data   (ld_data),
    .o_busy      (o_busy),
    .o_owner     (o_owner)
  );

  // Power-on memory image; the two directed words are part of it.
  function automatic logic [7:0] init_byte(input logic [11:0] a);
    case (a)
      12'h100: return 8'hEF;
      12'h101: return 8'hBE;
      12'h102: return 8'hAD;
      12'h103: return 8'hDE;
      12'h300: return 8'h0D;
      12'h301: return 8'hF0;
      12'h302: return 8'hAD;
      12'h303: return 8'h0B;
      default: return a[7:0] ^ {a[11:8], 4'h9} ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [7:0] b0, b1, b2, b3, input logic [2:0] sz);
    case (sz)
      3'd0:    return {{24{b0[7]}}, b0};
      3'd1:    return {24'h0, b0};
      3'd2:    return {{16{b1[7]}}, b1, b0};
      3'd3:    return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic logic [7:0] lsu_byte(input logic [11:0] a);
    logic [8:0] e;
    e = lsu_mem[a];
    return e[8] ? e[7:0] : init_byte(a);
  endfunction

  function automatic logic [31:0] lsu_word(input logic [11:0] a);
    return {lsu_byte(a + 12'd3), lsu_byte(a + 12'd2), lsu_byte(a + 12'd1), lsu_byte(a)};
  endfunction

  // LSU: combinational load, store committed on the clock edge.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ld_ent[k]  = lsu_mem[o_lsu_addr[11:0] + 12'(k)];
      ld_byte[k] = ld_ent[k][8] ? ld_ent[k][7:0] : init_byte(o_lsu_addr[11:0] + 12'(k));
    end
    ld_data = extend(ld_byte[0], ld_byte[1], ld_byte[2], ld_byte[3], o_num_byte);
  end

  always @(posedge i_clk) begin
    if (o_lsu_wren) begin
      lsu_mem[o_lsu_addr[11:0]] <= {1'b1, o_st_data[7:0]};
      if (o_num_byte >= 3'd2) lsu_mem[o_lsu_addr[11:0] + 12'd1] <= {1'b1, o_st_data[15:8]};
      if (o_num_byte >= 3'd4) begin
        lsu_mem[o_lsu_addr[11:0] + 12'd2] <= {1'b1, o_st_data[23:16]};
        lsu_mem[o_lsu_addr[11:0] + 12'd3] <= {1'b1, o_st_data[31:24]};
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] sz);
    return extend(ref_mem[a[11:0]], ref_mem[a[11:0] + 12'd1], ref_mem[a[11:0] + 12'd2],
                  ref_mem[a[11:0] + 12'd3], sz);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    ref_mem[a[11:0]] = d[7:0];
    if (sz >= 3'd2) ref_mem[a[11:0] + 12'd1] = d[15:8];
    if (sz >= 3'd4) begin
      ref_mem[a[11:0] + 12'd2] = d[23:16];
      ref_mem[a[11:0] + 12'd3] = d[31:24];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    ph = PH_IDLE; m_last = 1; m_owner = 0; m_cnt = 0; m_lock = 1'b0;
    c_wren = 1'b0; c_addr = '0; c_wdata = '0; c_size = '0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
  endtask

  task automatic issue(input int m, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] s, input bit l);
    req[m] = 1'b1; wren[m] = w; addr[m] = a; wdata[m] = d; size[m] = s; lck[m] = l;
  endtask

  task automatic issue_random(input int m);
    issue(m, 1'($urandom_range(0, 1)), 32'($urandom_range(32'h400, 32'hFF0)), $urandom,
          3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_m0_gnt"},    32'(o_m0_gnt),    32'd0);
    chk({tag, "_m1_gnt"},    32'(o_m1_gnt),    32'd0);
    chk({tag, "_m0_rvalid"}, 32'(o_m0_rvalid), 32'd0);
    chk({tag, "_m1_rvalid"}, 32'(o_m1_rvalid), 32'd0);
    chk({tag, "_wren"},      32'(o_lsu_wren),  32'd0);
    chk({tag, "_busy"},      32'(o_busy),      32'd0);
    chk({tag, "_m0_rdata"},  o_m0_rdata,       32'd0);
    chk({tag, "_m1_rdata"},  o_m1_rdata,       32'd0);
    chk({tag, "_addr"},      o_lsu_addr,       32'd0);
    chk({tag, "_st_data"},   o_st_data,        32'd0);
    chk({tag, "_num_byte"},  32'(o_num_byte),  32'd0);
    chk({tag, "_owner"},     32'(o_owner),     32'd0);
  endtask

  // One clock: compare every output with the model at the falling edge, then advance the model.
  task automatic step();
    int w;
    @(negedge i_clk);
    w = -1;
    if (ph != PH_ACCESS && (req[0] || req[1])) begin
      if (ph == PH_RESP && m_lock && req[m_owner] && !(m_cnt >= LOCK_MAX && req[1 - m_owner]))
        w = m_owner;
      else if (req[0] && req[1])
        w = 1 - m_last;
      else
        w = req[0] ? 0 : 1;
    end
    chk("m0_gnt",    32'(o_m0_gnt),    32'(w == 0));
    chk("m1_gnt",    32'(o_m1_gnt),    32'(w == 1));
    chk("busy",      32'(o_busy),      32'(ph == PH_ACCESS));
    chk("lsu_wren",  32'(o_lsu_wren),  32'(ph == PH_ACCESS && c_wren));
    chk("lsu_addr",  o_lsu_addr,       c_addr);
    chk("st_data",   o_st_data,        c_wdata);
    chk("num_byte",  32'(o_num_byte),  32'(c_size));
    chk("owner",     32'(o_owner),     32'(m_owner));
    chk("m0_rvalid", 32'(o_m0_rvalid), 32'(ph == PH_RESP && m_owner == 0));
    chk("m1_rvalid", 32'(o_m1_rvalid), 32'(ph == PH_RESP && m_owner == 1));
    chk("m0_rdata",  o_m0_rdata,       exp_rdata[0]);
    chk("m1_rdata",  o_m1_rdata,       exp_rdata[1]);
    seen_gnt[0] = o_m0_gnt;
    seen_gnt[1] = o_m1_gnt;
    if (w >= 0) begin
      if (!lck[w])          m_cnt = 0;
      else if (w == m_owner) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
      else                  m_cnt = 1;
      m_owner = w; m_last = w; m_lock = lck[w];
      c_wren = wren[w]; c_addr = addr[w]; c_wdata = wdata[w]; c_size = size[w];
      ph = PH_ACCESS;
    end else if (ph == PH_ACCESS) begin
      if (c_wren) begin
        exp_rdata[m_owner] = '0;
        ref_store(c_addr, c_wdata, c_size);
      end else begin
        exp_rdata[m_owner] = ref_load(c_addr, c_size);
      end
      ph = PH_RESP;
    end else begin
      ph = PH_IDLE;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    int  n0;
    int  prev;
    bit  got1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; wren[m] = 1'b0; lck[m] = 1'b0;
      addr[m] = '0; wdata[m] = '0; size[m] = '0;
    end
    i_reset = 1'b0;
    mdl_reset();
    #1;
    reset_checks("rst");
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1;

    // Single load from the preloaded word.
    issue(0, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0);
    step();
    chk("t1_gnt", 32'(seen_gnt[0]), 32'd1);
    req[0] = 1'b0;
    chk("t1_access_wren", 32'(o_lsu_wren), 32'd0);
    chk("t1_access_addr", o_lsu_addr, 32'h100);
    step();
    chk("t1_rvalid", 32'(o_m0_rvalid), 32'd1);
    chk("t1_rdata", o_m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", 32'(o_m1_rvalid), 32'd0);
    step();

    // Store word, then load an unsigned byte from it.
    issue(1, 1'b1, 32'h200, 32'h12345678, 3'd4, 1'b0);
    step();
    chk("t2_gnt", 32'(seen_gnt[1]), 32'd1);
    req[1] = 1'b0;
    chk("t2_wren_access", 32'(o_lsu_wren), 32'd1);
    step();
    chk("t2_wren_resp", 32'(o_lsu_wren), 32'd0);
    chk("t2_st_rvalid", 32'(o_m1_rvalid), 32'd1);
    issue(1, 1'b0, 32'h201, 32'h0, 3'd1, 1'b0);
    step();
    chk("t2_ld_gnt", 32'(seen_gnt[1]), 32'd1);
    req[1] = 1'b0;
    step();
    chk("t2_lbu_rdata", o_m1_rdata, 32'h00000056);
    step();

    // Continuous contention without lock.
    issue(0, 1'b0, 32'h104, 32'h0, 3'd4, 1'b0);
    issue(1, 1'b0, 32'h200, 32'h0, 3'd4, 1'b0);
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t3_gnt_cycle", 32'(seen_gnt[0] || seen_gnt[1]), 32'(i % 2 == 0));
      if (seen_gnt[0] || seen_gnt[1]) begin
        if (prev >= 0) chk("t3_alternate", 32'(seen_gnt[1]), 32'(1 - prev));
        prev = seen_gnt[1] ? 1 : 0;
      end
    end
    drain();

    // Request raised during another requester's ACCESS waits for RESP.
    issue(0, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0);
    step();
    chk("t4_m0_gnt", 32'(seen_gnt[0]), 32'd1);
    req[0] = 1'b0;
    issue(1, 1'b1, 32'h3F0, 32'hCAFEF00D, 3'd2, 1'b0);
    step();
    chk("t4_held_gnt", 32'(seen_gnt[1]), 32'd0);
    step();
    chk("t4_resp_gnt", 32'(seen_gnt[1]), 32'd1);
    req[1] = 1'b0;
    chk("t4_addr", o_lsu_addr, 32'h3F0);
    chk("t4_st_data", o_st_data, 32'hCAFEF00D);
    chk("t4_num_byte", 32'(o_num_byte), 32'd2);
    chk("t4_wren", 32'(o_lsu_wren), 32'd1);
    drain();

    // Bounded lock while the other requester waits, unbounded once it is idle.
    issue(0, 1'b0, 32'h104, 32'h0, 3'd4, 1'b1);
    step();
    chk("t5_first", 32'(seen_gnt[0]), 32'd1);
    n0 = 1;
    got1 = 1'b0;
    issue(1, 1'b0, 32'h108, 32'h0, 3'd4, 1'b0);
    for (int i = 0; i < 40 && !got1; i++) begin
      step();
      if (seen_gnt[0]) n0++;
      if (seen_gnt[1]) begin
        got1 = 1'b1;
        req[1] = 1'b0;
      end
    end
    chk("t5_run_len", 32'(n0), 32'(LOCK_MAX));
    chk("t5_m1_granted", 32'(got1), 32'd1);
    n0 = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (seen_gnt[0]) n0++;
      if (i >= 1) chk("t5_owner_kept", 32'(o_owner), 32'd0);
    end
    chk("t5_unbounded", 32'(n0), 32'd7);
    drain();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (!req[m] || seen_gnt[m]) begin
          if ($urandom_range(0, 99) < 60) issue_random(m);
          else req[m] = 1'b0;
        end
      end
    end
    drain();

    // Reset in the middle of a store's ACCESS cycle.
    issue(1, 1'b1, 32'h300, 32'hAAAA5555, 3'd4, 1'b0);
    step();
    chk("t6_gnt", 32'(seen_gnt[1]), 32'd1);
    chk("t6_wren_before", 32'(o_lsu_wren), 32'd1);
    issue(0, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0);
    issue(1, 1'b0, 32'h104, 32'h0, 3'd4, 1'b0);
    i_reset = 1'b0;
    #1;
    reset_checks("abort");
    @(posedge i_clk);
    #1;
    chk("t6_mem_unchanged", lsu_word(12'h300), 32'h0BADF00D);
    mdl_reset();
    i_reset = 1'b1;
    step();
    chk("t6_tie_m0", 32'(seen_gnt[0]), 32'd1);
    chk("t6_tie_not_m1", 32'(seen_gnt[1]), 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
